// File: rtl/regwb_pkg.sv
// Shared types for the register write-back queue: default widths,
// the pending-write entry layout and the int-r0 helper.
package regwb_pkg;

    localparam int REGWB_DATA_W = 32;
    localparam int REGWB_ADDR_W = 5;

    // One pending register write as held in the queue.
    typedef struct packed {
        logic                    is_float;
        logic [REGWB_ADDR_W-1:0] addr;
        logic [REGWB_DATA_W-1:0] data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Int r0 is hard-wired to zero; float r0 is an ordinary register.
    function automatic logic reads_zero(input logic                    is_float,
                                        input logic [REGWB_ADDR_W-1:0] addr);
        return !is_float && (addr == '0);
    endfunction

endpackage

// File: rtl/register_file.sv
// Plain register bank: one synchronous write port, NUM_RD combinational
// read ports. Contents are deliberately not reset.
module register_file #(
    parameter int NUM_RD = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Single write port, written when the queue retires into this bank.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        assign rdata[r*DATA_W +: DATA_W] = mem[raddr[r*ADDR_W +: ADDR_W]];
    end

endmodule

// File: rtl/regwb_match.sv
// Per-read-port search of the pending-write queue. Walks the queue from
// head (oldest) to tail so the last hit found is the newest pending write.
// Only the (float, addr) tag of each entry is needed here.
module regwb_match
    import regwb_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = REGWB_ADDR_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int TAG_W = 1 + ADDR_W
) (
    input  logic [DEPTH*TAG_W-1:0] tags,
    input  logic [DEPTH-1:0]       valid,
    input  logic [PTR_W-1:0]       head,
    input  logic [ADDR_W-1:0]      rd_addr,
    input  logic                   rd_float,
    output logic                   hit,
    output logic [PTR_W-1:0]       idx
);

    logic [PTR_W-1:0] slot;

    // Oldest-to-newest scan; int r0 never matches.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        slot = '0;
        if (!reads_zero(rd_float, rd_addr)) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot = head + PTR_W'(k);
                if (valid[slot] && (tags[slot*TAG_W +: TAG_W] == {rd_float, rd_addr})) begin
                    hit = 1'b1;
                    idx = slot;
                end
            end
        end
    end

endmodule

// File: rtl/register_wb_queue.sv
// Register write-back queue: accepts up to NUM_WB write-backs per cycle
// into an ordered FIFO, retires one per cycle into split int/float banks,
// and serves NUM_RD registered read ports.
// Build option: REGWB_BYPASS_EN forwards the newest pending value to reads;
// without it reads come from the banks only, rd_pending still flags hits.
module register_wb_queue
    import regwb_pkg::*;
#(
    parameter int NUM_WB = 4,
    parameter int NUM_RD = 2,
    parameter int DEPTH  = 8,
    parameter int DATA_W = REGWB_DATA_W,
    parameter int ADDR_W = REGWB_ADDR_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    input  logic [NUM_RD-1:0]          rd_float,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_pending,
    input  logic [NUM_WB-1:0]          wb_enable,
    input  logic [NUM_WB*ADDR_W-1:0]   wb_addr,
    input  logic [NUM_WB*DATA_W-1:0]   wb_data,
    input  logic [NUM_WB-1:0]          wb_float,
    output logic                       wb_ready,
    output logic [$clog2(DEPTH):0]     queue_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = ENTRY_W - REGWB_DATA_W;

    entry_t                   q [DEPTH];
    entry_t                   head_e;
    logic [PTR_W-1:0]         head, tail;
    logic [CNT_W-1:0]         count, req_cnt, free_cnt;
    logic [PTR_W-1:0]         slot [NUM_WB];
    logic [DEPTH-1:0]         valid;
    logic [DEPTH*TAG_W-1:0]   tags;
    logic                     retire, int_we, flt_we;
    logic [NUM_RD*DATA_W-1:0] irf_rdata, frf_rdata, rd_next;
    logic [NUM_RD-1:0]        hit;
    logic [PTR_W-1:0]         hit_idx [NUM_RD];

    function automatic logic [PTR_W-1:0] age_of(input int s, input logic [PTR_W-1:0] h);
        return PTR_W'(s) - h;
    endfunction

    // Request popcount and compacted destination slot for each channel.
    always_comb begin
        req_cnt = '0;
        for (int i = 0; i < NUM_WB; i++) begin
            slot[i] = tail + req_cnt[PTR_W-1:0];
            req_cnt = req_cnt + CNT_W'(wb_enable[i]);
        end
    end

    // Free space is judged on occupancy before this cycle's retire.
    assign free_cnt    = CNT_W'(DEPTH) - count;
    assign wb_ready    = (free_cnt >= req_cnt);
    assign retire      = (count != '0);
    assign queue_count = count;

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            valid[s] = ({1'b0, age_of(s, head)} < count);
        end
    end

    // Queue pointers and occupancy; reset drops every pending write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (retire) begin
                head <= head + 1'b1;
            end
            if (wb_ready) begin
                tail <= tail + req_cnt[PTR_W-1:0];
            end
            count <= count + (wb_ready ? req_cnt : '0) - CNT_W'(retire);
        end
    end

    // Entry storage: all-or-nothing append of the enabled channels.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_ready && wb_enable[i]) begin
                q[slot[i]] <= '{is_float: wb_float[i],
                                addr:     wb_addr[i*ADDR_W +: ADDR_W],
                                data:     wb_data[i*DATA_W +: DATA_W]};
            end
        end
    end

    for (genvar s = 0; s < DEPTH; s++) begin : g_tag
        assign tags[s*TAG_W +: TAG_W] = {q[s].is_float, q[s].addr};
    end

    // Retire the head entry; writes to int r0 are dropped here.
    assign head_e = q[head];
    assign int_we = retire && !head_e.is_float && !reads_zero(head_e.is_float, head_e.addr);
    assign flt_we = retire && head_e.is_float;

    register_file #(.NUM_RD(NUM_RD), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_int_rf (
        .clk   (clk),
        .we    (int_we),
        .waddr (head_e.addr),
        .wdata (head_e.data),
        .raddr (rd_addr),
        .rdata (irf_rdata)
    );

    register_file #(.NUM_RD(NUM_RD), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_flt_rf (
        .clk   (clk),
        .we    (flt_we),
        .waddr (head_e.addr),
        .wdata (head_e.data),
        .raddr (rd_addr),
        .rdata (frf_rdata)
    );

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] rf_val;

        assign addr = rd_addr[r*ADDR_W +: ADDR_W];

        regwb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_match (
            .tags     (tags),
            .valid    (valid),
            .head     (head),
            .rd_addr  (addr),
            .rd_float (rd_float[r]),
            .hit      (hit[r]),
            .idx      (hit_idx[r])
        );

        assign rf_val = reads_zero(rd_float[r], addr) ? '0 :
                        rd_float[r] ? frf_rdata[r*DATA_W +: DATA_W]
                                    : irf_rdata[r*DATA_W +: DATA_W];
`ifdef REGWB_BYPASS_EN
        assign rd_next[r*DATA_W +: DATA_W] = hit[r] ? q[hit_idx[r]].data : rf_val;
`else
        logic unused_idx;
        assign unused_idx = ^hit_idx[r];
        assign rd_next[r*DATA_W +: DATA_W] = rf_val;
`endif
    end

    // Registered read results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data    <= '0;
            rd_pending <= '0;
        end else begin
            rd_data    <= rd_next;
            rd_pending <= hit;
        end
    end

endmodule

// File: doc/register_wb_queue.md
Name: register_wb_queue

Overview:
- Parametrised successor to the fixed three-stage write-back chain.
- Accepts up to NUM_WB register write-backs per cycle from execution units (alu/mem/fpu/misc) into an ordered FIFO of DEPTH entries.
- Retires one entry per cycle into split int/float register files.
- Serves NUM_RD read ports with newest-pending-value forwarding; read data is registered.
- Sits between the execution units and the decode/operand-fetch stage.

Parameters:
- NUM_WB, 4, write-back channels per cycle; channel 0 is the oldest within a cycle.
- NUM_RD, 2, read ports (rs, rt, ...).
- DEPTH, 8, pending-write FIFO entries; power of two, DEPTH >= NUM_WB.
- DATA_W, 32, register width.
- ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read indices, packed, port 0 in LSBs
- rd_float  in  NUM_RD  1 = float bank
- rd_data  out  NUM_RD*DATA_W  registered read data
- rd_pending  out  NUM_RD  registered; 1 = a queued write matched this read
- wb_enable  in  NUM_WB  write-back request per channel
- wb_addr  in  NUM_WB*ADDR_W  destination indices
- wb_data  in  NUM_WB*DATA_W  write data
- wb_float  in  NUM_WB  1 = float bank
- wb_ready  out  1  combinational; free slots >= popcount(wb_enable)
- queue_count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset: FIFO empty (head = tail = 0), queue_count = 0, rd_data = 0, rd_pending = 0. Register-file arrays are not reset.
- Enqueue is all-or-nothing:
  - If wb_ready, every enabled channel is appended in channel order (0 first, compacted; disabled channels leave no gap).
  - If not wb_ready, nothing is accepted. Producers hold their request until ready.
- Retire: when the queue is non-empty at a clock edge, the head entry is written to the bank selected by its float bit, and head advances.
  - Retire and enqueue in the same cycle are allowed. Free-slot computation uses occupancy before that cycle's retire (conservative).
- Pointers wrap modulo DEPTH. queue_count = previous count + accepted − retired. It never exceeds DEPTH; a full queue with any request gives wb_ready = 0.
- Int register 0 reads as 0 and never matches the forwarding compare. Writes to int r0 are enqueued but discarded at retire. Float r0 is an ordinary register.
- Read, per port (1-cycle latency):
  - Compare (addr, float) against all valid queue entries. The newest match (closest to tail) supplies the data.
  - Otherwise the register-file value is used. The result is captured into rd_data on the next edge.
  - Writes being enqueued in the same cycle are not visible to that cycle's read.
  - The head entry being retired that cycle still forwards, so there is no gap.
- Simultaneous duplicate destinations within one cycle: the higher channel index wins later reads, because it is newer.
- Reset asserted mid-operation drops all pending writes immediately. Register-file contents are retained.

Optional Feature:
- Macro REGWB_BYPASS_EN.
- Defined: forwarding as above.
- Undefined: reads come only from the register files, and rd_pending still reports matches so the decode stage can stall. This saves the data mux; the compare logic stays.

Decomposition:
- Shared package regwb_pkg: DATA_W/ADDR_W defaults, the entry struct {float, addr, data}, and an ENTRY_W constant.
- One natural sub-module, regwb_match, instantiated once per read port. It takes the queue entries, valid mask, head pointer and a read request, and returns the hit flag and newest-match index.
- The existing register_file is instantiated twice, once per bank.

Test Plan:
- Reset then idle: rd_data = 0, rd_pending = 0, queue_count = 0, wb_ready = 1.
- Single write of int r3 = 0x1234: read r3 in the next cycle gives rd_pending = 1 and rd_data = 0x1234 (forwarded). Two cycles later rd_pending = 0 and rd_data = 0x1234 from the register file.
- Same-cycle writes: channel 0 int r5 = 0xA, channel 2 int r5 = 0xB. A subsequent read of r5 returns 0xB throughout queue residency and after retire. Float f5 written 0xC on channel 1 reads 0xC independently.
- Fill: 4 writes/cycle for 3 cycles with DEPTH = 8.
  - Cycle 3: wb_ready = 0 and nothing is enqueued; queue_count stays at 7.
  - Once free slots reach 4, wb_ready rises and the held request is accepted whole.
  - Pointer wrap is verified by readback of all values.
- Int r0 write 0xFFFF: reads of r0 return 0 at all times. Float f0 write 0xFFFF reads 0xFFFF.
- Reset asserted while queue_count = 5: all outputs clear asynchronously. Entries already retired remain readable afterwards; dropped entries are not written.
